lane_result_wb_arbiter: RTL and testbench

// - Per-lane write-back stage directly downstream of the vector FU stage.
// - Buffers ALU and MFPU result writes independently, then round-robin arbitrates them onto the single VRF write port.
// - Decouples FU result grant from VRF back-pressure.
// - Reports per-instruction write retirement to the lane sequencer.

---
 rtl/lane_result_wb_arbiter_pkg.sv | 21 ++
 rtl/lane_result_wb_arbiter_fifo.sv | 66 ++++++
 rtl/lane_result_wb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_lane_result_wb_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_result_wb_arbiter_pkg.sv
// Shared types for the lane write-back stage: instruction ids, element data,
// byte strobes and the write-back source selector.
package lane_result_wb_arbiter_pkg;

  localparam int unsigned NrVInsn = 8;
  localparam int unsigned ELEN    = 64;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [ELEN/8-1:0]          strb_t;

  typedef enum logic {
    WbSrcAlu,
    WbSrcMfpu
  } wb_src_e;

  function automatic wb_src_e other_src(input wb_src_e src);
    return (src == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
  endfunction

endpackage

// File: rtl/lane_result_wb_arbiter_fifo.sv
// Small circular buffer for one write-back source. Pointers wrap explicitly at
// Depth-1 so any depth >= 1 works; full/empty come from the occupancy counter.
module lane_wb_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  entry_t            r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign data_o  = r_mem[r_rd_ptr];

  // A full buffer never takes a push, even when it pops in the same cycle.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lane_result_wb_arbiter.sv
// Lane write-back stage: buffers ALU and MFPU result writes independently and
// round-robins the buffer heads onto the single VRF write port.
module lane_result_wb_arbiter
  import lane_result_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned BufDepth = 2,
  parameter type         vaddr_t  = logic
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alu_result_req_i,
  input  vid_t               alu_result_id_i,
  input  vaddr_t             alu_result_addr_i,
  input  elen_t              alu_result_wdata_i,
  input  strb_t              alu_result_be_i,
  output logic               alu_result_gnt_o,
  input  logic               mfpu_result_req_i,
  input  vid_t               mfpu_result_id_i,
  input  vaddr_t             mfpu_result_addr_i,
  input  elen_t              mfpu_result_wdata_i,
  input  strb_t              mfpu_result_be_i,
  output logic               mfpu_result_gnt_o,
  output logic               vrf_wr_valid_o,
  output vid_t               vrf_wr_id_o,
  output vaddr_t             vrf_wr_addr_o,
  output elen_t              vrf_wr_wdata_o,
  output strb_t              vrf_wr_be_o,
  input  logic               vrf_wr_ready_i,
  output logic [NrVInsn-1:0] vinsn_written_o,
  output logic               wb_idle_o
);

  if (BufDepth < 1 || NrLanes < 1) begin : g_bad_params
    $error("lane_result_wb_arbiter: BufDepth and NrLanes must be >= 1");
  end

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } wb_entry_t;

  wb_entry_t w_alu_in;
  wb_entry_t w_mfpu_in;
  wb_entry_t w_alu_head;
  wb_entry_t w_mfpu_head;
  wb_entry_t w_head;
  logic      w_alu_full;
  logic      w_alu_empty;
  logic      w_mfpu_full;
  logic      w_mfpu_empty;
  logic      w_alu_valid;
  logic      w_mfpu_valid;
  logic      w_pop;
  logic      w_alu_pop;
  logic      w_mfpu_pop;
  wb_src_e   w_sel;

  wb_src_e   r_rr;
  logic      r_lock;
  wb_src_e   r_lock_src;
  wb_src_e   w_rr_d;
  logic      w_lock_d;
  wb_src_e   w_lock_src_d;

  assign w_alu_in  = '{id: alu_result_id_i,  addr: alu_result_addr_i,
                       wdata: alu_result_wdata_i,  be: alu_result_be_i};
  assign w_mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                       wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

  // Grant depends only on the request and registered occupancy, never on VRF ready.
  assign alu_result_gnt_o  = alu_result_req_i  & ~w_alu_full;
  assign mfpu_result_gnt_o = mfpu_result_req_i & ~w_mfpu_full;

  lane_wb_fifo #(
    .Depth   (BufDepth),
    .entry_t (wb_entry_t)
  ) i_alu_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (alu_result_gnt_o),
    .data_i  (w_alu_in),
    .pop_i   (w_alu_pop),
    .data_o  (w_alu_head),
    .full_o  (w_alu_full),
    .empty_o (w_alu_empty)
  );

  lane_wb_fifo #(
    .Depth   (BufDepth),
    .entry_t (wb_entry_t)
  ) i_mfpu_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mfpu_result_gnt_o),
    .data_i  (w_mfpu_in),
    .pop_i   (w_mfpu_pop),
    .data_o  (w_mfpu_head),
    .full_o  (w_mfpu_full),
    .empty_o (w_mfpu_empty)
  );

  assign w_alu_valid  = ~w_alu_empty;
  assign w_mfpu_valid = ~w_mfpu_empty;

  // A stalled presentation keeps its source, so a late arrival cannot steal the port.
  always_comb begin
    w_sel = r_rr;
    if (r_lock) begin
      w_sel = r_lock_src;
    end else if (w_alu_valid && !w_mfpu_valid) begin
      w_sel = WbSrcAlu;
    end else if (w_mfpu_valid && !w_alu_valid) begin
      w_sel = WbSrcMfpu;
    end
  end

  assign w_head         = (w_sel == WbSrcMfpu) ? w_mfpu_head : w_alu_head;
  assign vrf_wr_valid_o = w_alu_valid | w_mfpu_valid;
  assign vrf_wr_id_o    = w_head.id;
  assign vrf_wr_addr_o  = w_head.addr;
  assign vrf_wr_wdata_o = w_head.wdata;
  assign vrf_wr_be_o    = w_head.be;

  assign w_pop      = vrf_wr_valid_o & vrf_wr_ready_i;
  assign w_alu_pop  = w_pop & (w_sel == WbSrcAlu);
  assign w_mfpu_pop = w_pop & (w_sel == WbSrcMfpu);

  always_comb begin
    vinsn_written_o = '0;
    if (w_pop) begin
      vinsn_written_o[w_head.id] = 1'b1;
    end
  end

  assign wb_idle_o = w_alu_empty & w_mfpu_empty;

  always_comb begin
    w_rr_d       = r_rr;
    w_lock_d     = r_lock;
    w_lock_src_d = r_lock_src;
    if (w_pop) begin
      w_rr_d   = other_src(w_sel);
      w_lock_d = 1'b0;
    end else if (vrf_wr_valid_o) begin
      w_lock_d     = 1'b1;
      w_lock_src_d = w_sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= WbSrcAlu;
      r_lock     <= 1'b0;
      r_lock_src <= WbSrcAlu;
    end else begin
      r_rr       <= w_rr_d;
      r_lock     <= w_lock_d;
      r_lock_src <= w_lock_src_d;
    end
  end

endmodule

// File: tb/tb_lane_result_wb_arbiter.sv
// Directed bench for lane_result_wb_arbiter: per-source expected queues, a
// negedge monitor for every VRF write, and hand-computed scenario checks.
module tb_lane_result_wb_arbiter;

  localparam int EW = 3 + 16 + 64 + 8;

  logic        clk;
  logic        rst_i;
  logic        alu_req;
  logic [2:0]  alu_id;
  logic [15:0] alu_addr;
  logic [63:0] alu_wdata;
  logic [7:0]  alu_be;
  logic        alu_gnt;
  logic        mfpu_req;
  logic [2:0]  mfpu_id;
  logic [15:0] mfpu_addr;
  logic [63:0] mfpu_wdata;
  logic [7:0]  mfpu_be;
  logic        mfpu_gnt;
  logic        vrf_valid;
  logic [2:0]  vrf_id;
  logic [15:0] vrf_addr;
  logic [63:0] vrf_wdata;
  logic [7:0]  vrf_be;
  logic        vrf_ready;
  logic [7:0]  vinsn_written;
  logic        wb_idle;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int alu_stalls  = 0;
  int mfpu_stalls = 0;
  int mfpu_grants = 0;

  logic [EW-1:0] exp_alu_q[$];
  logic [EW-1:0] exp_mfpu_q[$];
  int            pop_src_q[$];

  lane_result_wb_arbiter #(
    .NrLanes  (4),
    .BufDepth (2),
    .vaddr_t  (logic [15:0])
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .alu_result_req_i    (alu_req),
    .alu_result_id_i     (alu_id),
    .alu_result_addr_i   (alu_addr),
    .alu_result_wdata_i  (alu_wdata),
    .alu_result_be_i     (alu_be),
    .alu_result_gnt_o    (alu_gnt),
    .mfpu_result_req_i   (mfpu_req),
    .mfpu_result_id_i    (mfpu_id),
    .mfpu_result_addr_i  (mfpu_addr),
    .mfpu_result_wdata_i (mfpu_wdata),
    .mfpu_result_be_i    (mfpu_be),
    .mfpu_result_gnt_o   (mfpu_gnt),
    .vrf_wr_valid_o      (vrf_valid),
    .vrf_wr_id_o         (vrf_id),
    .vrf_wr_addr_o       (vrf_addr),
    .vrf_wr_wdata_o      (vrf_wdata),
    .vrf_wr_be_o         (vrf_be),
    .vrf_wr_ready_i      (vrf_ready),
    .vinsn_written_o     (vinsn_written),
    .wb_idle_o           (wb_idle)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Entry layout {id, addr, wdata, be}; wdata[63:56] tags the source (A1 = ALU, B2 = MFPU).
  function automatic logic [EW-1:0] make_entry(input bit is_mfpu, input int seq);
    logic [2:0]  id;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    id    = 3'(seq);
    addr  = 16'(seq * 4) | (is_mfpu ? 16'h1000 : 16'h0000);
    wdata = {(is_mfpu ? 8'hB2 : 8'hA1), 24'h0, 32'(seq)};
    be    = 8'hFF ^ 8'(seq);
    return {id, addr, wdata, be};
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_i     = 1'b1;
    alu_req   = 1'b0;
    mfpu_req  = 1'b0;
    vrf_ready = 1'b1;
    exp_alu_q.delete();
    exp_mfpu_q.delete();
    pop_src_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Driver tasks: called just after a rising edge; hold each request until granted.
  task automatic drive_alu(input int n, input int seq0);
    logic [EW-1:0] e;
    bit got;
    for (int k = 0; k < n; k++) begin
      e = make_entry(1'b0, seq0 + k);
      {alu_id, alu_addr, alu_wdata, alu_be} = e;
      alu_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (alu_gnt) begin
          got = 1'b1;
          exp_alu_q.push_back(e);
        end else begin
          alu_stalls++;
        end
        @(posedge clk); #1;
      end
      check("alu granted within budget", 64'(got), 64'd1);
    end
    alu_req = 1'b0;
  endtask

  task automatic drive_mfpu(input int n, input int seq0);
    logic [EW-1:0] e;
    bit got;
    for (int k = 0; k < n; k++) begin
      e = make_entry(1'b1, seq0 + k);
      {mfpu_id, mfpu_addr, mfpu_wdata, mfpu_be} = e;
      mfpu_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (mfpu_gnt) begin
          got = 1'b1;
          exp_mfpu_q.push_back(e);
          mfpu_grants++;
        end else begin
          mfpu_stalls++;
        end
        @(posedge clk); #1;
      end
      check("mfpu granted within budget", 64'(got), 64'd1);
    end
    mfpu_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = wb_idle;
    end
    check("idle reached", 64'(ok), 64'd1);
  endtask

  // Scoreboard: every retired write must match the head of its source's queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    bit is_m;
    if (!rst_i) begin
      if (vinsn_written != 8'h00) n_pulses++;
      if (vrf_valid && vrf_ready) begin
        is_m = (vrf_wdata[63:56] == 8'hB2);
        pop_src_q.push_back(is_m ? 1 : 0);
        check("pending entry for popped source",
              64'(is_m ? (exp_mfpu_q.size() > 0) : (exp_alu_q.size() > 0)), 64'd1);
        if (is_m ? (exp_mfpu_q.size() > 0) : (exp_alu_q.size() > 0)) begin
          e = is_m ? exp_mfpu_q.pop_front() : exp_alu_q.pop_front();
          check("wb wdata", vrf_wdata, e[71:8]);
          check("wb id/addr/be", {vrf_id, vrf_addr, vrf_be}, {e[90:88], e[87:72], e[7:0]});
          check("retire one-hot", vinsn_written, 8'h01 << e[90:88]);
        end
      end else begin
        check("no retire without pop", vinsn_written, 8'h00);
      end
    end
  end

  initial begin
    logic [EW-1:0] e;
    logic [63:0]   held;
    int            p0;
    int            ones;

    rst_i = 1'b1; vrf_ready = 1'b1;
    alu_req = 1'b0; alu_id = '0; alu_addr = '0; alu_wdata = '0; alu_be = '0;
    mfpu_req = 1'b0; mfpu_id = '0; mfpu_addr = '0; mfpu_wdata = '0; mfpu_be = '0;

    // Reset state
    #3;
    check("reset valid", vrf_valid, 0);
    check("reset vinsn", vinsn_written, 0);
    check("reset idle", wb_idle, 1);
    check("reset alu gnt", alu_gnt, 0);
    check("reset mfpu gnt", mfpu_gnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;

    // Single ALU write: id 2, addr 0x10, be 0xFF
    e = {3'd2, 16'h0010, 64'hA100_0000_DEAD_BEEF, 8'hFF};
    {alu_id, alu_addr, alu_wdata, alu_be} = e;
    alu_req = 1'b1;
    exp_alu_q.push_back(e);
    @(negedge clk);
    check("single gnt same cycle", alu_gnt, 1);
    check("single not presented yet", vrf_valid, 0);
    @(posedge clk); #1;
    alu_req = 1'b0;
    @(negedge clk);
    check("single valid next cycle", vrf_valid, 1);
    check("single id", vrf_id, 2);
    check("single addr", vrf_addr, 16'h0010);
    check("single be", vrf_be, 8'hFF);
    check("single retire pulse", vinsn_written, 8'h04);
    @(negedge clk);
    check("single pulse one cycle", vinsn_written, 8'h00);
    check("single valid drops", vrf_valid, 0);
    check("single idle", wb_idle, 1);

    // Both sources, 4 writes each, ready stuck high: A,M,A,M,...
    reset_dut();
    alu_stalls = 0; mfpu_stalls = 0;
    fork
      drive_alu(4, 100);
      drive_mfpu(4, 200);
    join
    wait_idle(50);
    check("alternation pop count", 64'(pop_src_q.size()), 64'd8);
    for (int i = 0; i < pop_src_q.size() && i < 8; i++)
      check("alternation order", 64'(pop_src_q[i]), 64'(i % 2));
    check("alu gnt stalled on full", 64'(alu_stalls > 0), 64'd1);
    check("mfpu gnt stalled on full", 64'(mfpu_stalls > 0), 64'd1);

    // Ready low for 5 cycles with both requesting
    reset_dut();
    vrf_ready = 1'b0;
    e = make_entry(1'b0, 110);
    fork
      drive_alu(3, 110);
      drive_mfpu(3, 210);
    join_none
    @(negedge clk);
    @(negedge clk);
    held = vrf_wdata;
    check("stall first presented is alu", held, e[71:8]);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall valid held", vrf_valid, 1);
      check("stall payload constant", vrf_wdata, held);
    end
    check("stall alu gnt drops", alu_gnt, 0);
    check("stall mfpu gnt drops", mfpu_gnt, 0);
    check("stall not idle", wb_idle, 0);
    @(posedge clk); #1;
    vrf_ready = 1'b1;
    wait fork;
    wait_idle(50);

    // Locked selection: rr points at MFPU but a stalled ALU head keeps the port
    reset_dut();
    drive_alu(1, 50);
    wait_idle(20);
    @(posedge clk); #1;
    vrf_ready = 1'b0;
    drive_alu(1, 51);
    e = make_entry(1'b0, 51);
    fork
      drive_mfpu(1, 52);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lock keeps alu head", vrf_wdata, e[71:8]);
    end
    @(posedge clk); #1;
    vrf_ready = 1'b1;
    wait fork;
    wait_idle(20);
    check("lock pop order", 64'({pop_src_q[1], pop_src_q[2]}), 64'(64'b01));

    // Full FIFO popping with ready high still refuses the push; order across wrap
    reset_dut();
    vrf_ready = 1'b0;
    fork
      drive_alu(5, 400);
    join_none
    repeat (3) @(posedge clk);
    #1;
    vrf_ready = 1'b1;
    @(negedge clk);
    check("full+pop no grant", alu_gnt, 0);
    check("full+pop valid", vrf_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("grant after pop", alu_gnt, 1);
    wait fork;
    wait_idle(50);
    check("wrap all retired", 64'(exp_alu_q.size()), 64'd0);

    // Reset with three writes buffered
    reset_dut();
    vrf_ready = 1'b0;
    e = make_entry(1'b0, 60);
    {alu_id, alu_addr, alu_wdata, alu_be} = e;
    e = make_entry(1'b1, 61);
    {mfpu_id, mfpu_addr, mfpu_wdata, mfpu_be} = e;
    alu_req = 1'b1; mfpu_req = 1'b1;
    @(posedge clk); #1;
    mfpu_req = 1'b0;
    e = make_entry(1'b0, 62);
    {alu_id, alu_addr, alu_wdata, alu_be} = e;
    @(posedge clk); #1;
    alu_req = 1'b0;
    @(negedge clk);
    check("buffered before reset valid", vrf_valid, 1);
    check("buffered before reset idle", wb_idle, 0);
    @(posedge clk); #1;
    p0 = n_pulses;
    rst_i = 1'b1;
    vrf_ready = 1'b1;
    #1;
    check("mid reset valid", vrf_valid, 0);
    check("mid reset idle", wb_idle, 1);
    check("mid reset vinsn", vinsn_written, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post reset valid", vrf_valid, 0);
      check("post reset idle", wb_idle, 1);
    end
    check("dropped writes not retired", 64'(n_pulses - p0), 64'd0);

    // MFPU only, 8 writes, random ready
    reset_dut();
    mfpu_grants = 0;
    p0 = n_pulses;
    fork
      drive_mfpu(8, 300);
    join_none
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      vrf_ready = 1'($urandom_range(0, 1));
      if (mfpu_grants == 8 && wb_idle) break;
    end
    vrf_ready = 1'b1;
    wait fork;
    wait_idle(20);
    check("mfpu retire pulses", 64'(n_pulses - p0), 64'd8);
    check("mfpu queue drained", 64'(exp_mfpu_q.size()), 64'd0);
    ones = 0;
    foreach (pop_src_q[i]) ones += pop_src_q[i];
    check("mfpu pops all from mfpu", 64'(ones), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
